// File: rtl/crc32_pkg.sv
// Shared constants and types for the CRC32 frame checker.
package crc32_pkg;

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    // Register value left after running a good frame, FCS included, through the LSB-first update
    localparam logic [31:0] RESIDUE  = 32'hDEBB_20E3;

    typedef enum logic [1:0] {IDLE, ACTIVE, RESULT} state_t;
    typedef logic [15:0] len_t;

endpackage

// File: rtl/crc32_frame_check_update.sv
// Combinational CRC32 byte update, reflected polynomial, data LSB first.
module crc32_frame_check_update
    import crc32_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = {1'b0, c[31:1]} ^ ((c[0] ^ data[i]) ? CRC_POLY : 32'h0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc32_frame_check.sv
// Byte-stream Ethernet FCS checker: one result per sof..eof frame, with length limits.
module crc32_frame_check
    import crc32_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_sof,
    input  logic        s_eof,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_ok,
    output logic [31:0] m_crc,
    output logic [15:0] m_len,
    output logic        m_runt,
    output logic        m_long,
    output logic        abort
);

    localparam len_t MIN_L = len_t'(MIN_LEN);
    localparam len_t MAX_L = len_t'(MAX_LEN);

    state_t      state, state_n;
    logic [31:0] crc, crc_n, upd_in, upd_out;
    len_t        len, len_n;
    logic        abort_n, acc, in_res, runt, lng;

    // A start-of-frame beat always restarts from the init value, even mid-frame
    assign upd_in = (state == IDLE || s_sof) ? CRC_INIT : crc;

    crc32_frame_check_update u_upd (
        .crc_in  (upd_in),
        .data    (s_data),
        .crc_out (upd_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            crc   <= CRC_INIT;
            len   <= '0;
            abort <= 1'b0;
        end else begin
            state <= state_n;
            crc   <= crc_n;
            len   <= len_n;
            abort <= abort_n;
        end
    end

    always_comb begin
        state_n = state;
        crc_n   = crc;
        len_n   = len;
        abort_n = 1'b0;
        s_ready = !rst && (state != RESULT);
        acc     = s_valid && s_ready;
        case (state)
            IDLE: begin
                if (acc && s_sof) begin
                    crc_n   = upd_out;
                    len_n   = 16'd1;
                    state_n = s_eof ? RESULT : ACTIVE;
                end
            end
            ACTIVE: begin
                if (acc) begin
                    crc_n   = upd_out;
                    abort_n = s_sof;
                    if (s_sof)              len_n = 16'd1;
                    else if (len != 16'hFFFF) len_n = len + 16'd1;
                    state_n = s_eof ? RESULT : ACTIVE;
                end
            end
            RESULT: begin
                if (m_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Result fields are held at zero outside RESULT so reset shows all-zero outputs
    assign in_res  = (state == RESULT);
    assign runt    = len < MIN_L;
    assign lng     = len > MAX_L;
    assign m_valid = in_res;
    assign m_runt  = in_res && runt;
    assign m_long  = in_res && lng;
    assign m_ok    = in_res && (crc == RESIDUE) && !runt && !lng;
    assign m_crc   = in_res ? ~crc : 32'h0;
    assign m_len   = in_res ? len : 16'h0;

endmodule

// File: tb/tb_crc32_frame_check.sv
// Scoreboard bench for crc32_frame_check against a bit-serial Ethernet CRC model.
module tb_crc32_frame_check;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [15:0] len;
        logic        ok;
        logic        runt;
        logic        lng;
        logic [31:0] crc;
    } exp_t;

    logic        clk, rst, s_valid, s_ready, s_sof, s_eof, m_valid, m_ready;
    logic        m_ok, m_runt, m_long, abort;
    logic [7:0]  s_data;
    logic [31:0] m_crc;
    logic [15:0] m_len;

    int   n_tests = 0, n_fail = 0, n_res = 0, n_abort = 0;
    exp_t sb[$];
    exp_t me;

    crc32_frame_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid), .m_ready(m_ready), .m_ok(m_ok),
        .m_crc(m_crc), .m_len(m_len), .m_runt(m_runt), .m_long(m_long), .abort(abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Ethernet CRC register (no final inversion), one bit at a time
    function automatic logic [31:0] crc_reg(input bq_t d);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (d[i]) begin
            for (int k = 0; k < 8; k++) begin
                if (c[0] != d[i][k]) c = (c >> 1) ^ 32'hEDB8_8320;
                else                 c = c >> 1;
            end
        end
        return c;
    endfunction

    function automatic bq_t good(input int n);
        bq_t f;
        logic [31:0] fcs;
        for (int i = 0; i < n - 4; i++) f.push_back(8'($urandom));
        fcs = ~crc_reg(f);
        for (int b = 0; b < 4; b++) f.push_back(fcs[8*b +: 8]);
        return f;
    endfunction

    task automatic expect_fr(input bq_t f, input bit ok);
        exp_t e;
        e.len  = 16'(f.size());
        e.runt = f.size() < 64;
        e.lng  = f.size() > 1518;
        e.ok   = ok && !e.runt && !e.lng;
        e.crc  = ~crc_reg(f);
        sb.push_back(e);
    endtask

    task automatic send(input bq_t fr, input bit close);
        for (int i = 0; i < fr.size(); i++) begin
            s_valid = 1'b1;
            s_data  = fr[i];
            s_sof   = (i == 0);
            s_eof   = close && (i == fr.size() - 1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (m_valid) chk("idle_timeout", 32'(m_valid), 0);
    endtask

    task automatic frame(input bq_t f, input bit ok);
        expect_fr(f, ok);
        send(f, 1'b1);
        chk("latency", 32'(m_valid), 1);
        wait_idle();
    endtask

    always @(negedge clk) begin
        if (abort) n_abort++;
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                me = sb.pop_front();
                chk("len",  32'(m_len),  32'(me.len));
                chk("ok",   32'(m_ok),   32'(me.ok));
                chk("runt", 32'(m_runt), 32'(me.runt));
                chk("long", 32'(m_long), 32'(me.lng));
                chk("crc",  m_crc,       me.crc);
                n_res++;
            end
        end
    end

    initial begin
        bq_t f;
        logic [31:0] hold_crc;
        int res0, ab0;
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h0; s_sof = 1'b0; s_eof = 1'b0; m_ready = 1'b1;
        #2;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_outs", {m_crc[15:0], m_len[12:0], m_ok, m_runt, m_long}, 0);
        chk("rst_abort", 32'(abort), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_rst_ready", 32'(s_ready), 1);

        // good / corrupted / short / long / single-byte frames
        f = good(64);
        frame(f, 1'b1);
        f[10] = f[10] ^ 8'h08;
        frame(f, 1'b0);
        frame(good(20), 1'b1);
        frame(good(1519), 1'b1);
        f = good(5);
        f = f[0:0];
        frame(f, 1'b0);

        // result held under backpressure while upstream keeps offering beats
        m_ready = 1'b0;
        f = good(64);
        expect_fr(f, 1'b1);
        hold_crc = ~crc_reg(f);
        send(f, 1'b1);
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_sof = 1'b1; s_eof = 1'b1; s_data = 8'($urandom);
            @(posedge clk); #1;
            chk("hold_s_ready", 32'(s_ready), 0);
            chk("hold_valid", 32'(m_valid), 1);
            chk("hold_len", 32'(m_len), 64);
            chk("hold_crc", m_crc, hold_crc);
        end
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_idle", 32'(m_valid), 0);
        chk("release_ready", 32'(s_ready), 1);
        frame(good(64), 1'b1);

        // mid-frame restart aborts the open frame
        res0 = n_res; ab0 = n_abort;
        send(good(30), 1'b0);
        frame(good(64), 1'b1);
        chk("abort_pulses", n_abort - ab0, 1);
        chk("abort_results", n_res - res0, 1);

        // stray beats without sof are dropped
        res0 = n_res;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_sof = 1'b0; s_eof = (i % 2 == 1); s_data = 8'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_eof = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("stray_no_valid", 32'(m_valid), 0);
        chk("stray_no_result", n_res - res0, 0);

        // reset mid-frame
        ab0 = n_abort;
        send(good(40), 1'b0);
        #2 rst = 1'b1;
        #2 chk("midrst_ready", 32'(s_ready), 0);
        @(posedge clk); #1 rst = 1'b0;
        #1 chk("midrst_post_ready", 32'(s_ready), 1);
        chk("midrst_post_valid", 32'(m_valid), 0);
        repeat (2) @(posedge clk);
        #1 chk("midrst_abort", n_abort - ab0, 0);
        frame(good(64), 1'b1);

        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crc32_frame_check.md
CRC32_FRAME_CHECK -- requirements
Module: crc32_frame_check

Interface
REQ-001 Parameter MIN_LEN, default 64: minimum legal frame length in bytes, FCS included.
REQ-002 Parameter MAX_LEN, default 1518: maximum legal frame length in bytes, FCS included.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s_valid  input  1  byte-stream beat valid.
REQ-006 s_ready  output  1  checker can accept a beat.
REQ-007 s_data  input  8  frame byte; payload followed by the 4 FCS bytes.
REQ-008 s_sof  input  1  beat is the first byte of a frame.
REQ-009 s_eof  input  1  beat is the last byte of a frame.
REQ-010 m_valid  output  1  frame result valid.
REQ-011 m_ready  input  1  downstream accepts the result.
REQ-012 m_ok  output  1  CRC residue correct and length legal.
REQ-013 m_crc  output  32  bitwise-inverted final CRC register.
REQ-014 m_len  output  16  frame byte count, saturating at 0xFFFF.
REQ-015 m_runt  output  1  m_len < MIN_LEN.
REQ-016 m_long  output  1  m_len > MAX_LEN.
REQ-017 abort  output  1  one-cycle pulse: an open frame was discarded by a new s_sof.

Function
REQ-018 A beat is accepted when s_valid and s_ready are both high in the same cycle.
REQ-019 FSM states: IDLE, ACTIVE, RESULT.
REQ-020 IDLE: s_ready=1. An accepted beat with s_sof=0 is dropped without effect.
REQ-021 IDLE: an accepted beat with s_sof=1 loads crc = update(CRC_INIT, s_data) and len=1. Next state is ACTIVE, or RESULT if s_eof=1.
REQ-022 ACTIVE: s_ready=1. Each accepted beat does crc = update(crc, s_data) and len = len+1 (saturating). s_eof=1 moves to RESULT.
REQ-023 ACTIVE, accepted beat with s_sof=1: pulse abort the next cycle, emit no result, restart per REQ-021 on that same beat.
REQ-024 update() is the existing combinational CRC32 byte-update function: crcIn = current register, data = s_data, single cycle, zero added latency.
REQ-025 RESULT: s_ready=0 and m_valid=1.
REQ-026 In RESULT, m_crc, m_len, m_runt and m_long are registered values and stay stable until the m_valid&&m_ready handshake.
REQ-027 In RESULT, m_ok = (crc == RESIDUE) && !m_runt && !m_long.
REQ-028 The m_valid&&m_ready handshake returns the FSM to IDLE. No beat is accepted in that cycle.
REQ-029 m_valid asserts the cycle after the s_eof beat is accepted (latency 1), and may already be high while m_ready is low.
REQ-030 s_sof and s_eof on the same beat form a 1-byte frame: m_len=1, m_runt=1, m_ok=0.
REQ-031 m_len stops incrementing at 0xFFFF. m_long stays 1.
REQ-032 s_data, s_sof and s_eof are ignored whenever s_ready=0 or s_valid=0.

Reset
REQ-033 rst asynchronously forces state=IDLE, crc=CRC_INIT, len=0.
REQ-034 During reset all outputs are 0, except s_ready, which is 1 once rst deasserts.
REQ-035 Reset mid-frame or in RESULT discards the frame and emits no abort pulse.

Structure
REQ-036 Package crc32_pkg holds: CRC_INIT=32'hFFFFFFFF, RESIDUE (the good-frame residue for the update ordering), the FSM state enum, and the length type (16 bit).
REQ-037 One sub-module: the existing combinational CRC32 update block, instantiated once. No other hierarchy.

Verification
REQ-038 64-byte frame with correct FCS from the golden model, m_ready=1 -> m_valid one cycle after eof, m_ok=1, m_len=64, m_crc matches model.
REQ-039 Same frame with one payload bit flipped -> m_ok=0, m_runt=0, m_long=0, m_len=64.
REQ-040 20-byte good-FCS frame -> m_runt=1, m_ok=0, m_len=20. 1519-byte frame -> m_long=1, m_ok=0.
REQ-041 Result held with m_ready=0 for 10 cycles while s_valid=1 -> s_ready=0 throughout, outputs stable. m_ready=1 -> IDLE next cycle, next sof accepted.
REQ-042 s_sof after 30 bytes, then a 64-byte good frame -> one abort pulse, single result with m_len=64, m_ok=1. Stray beats without sof in IDLE -> no result.
REQ-043 rst asserted after 40 bytes -> s_ready=1 and m_valid=0 after release, no abort pulse. Next 64-byte good frame -> m_ok=1.
